timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised bank of N independent down-counting interval timers with sticky interrupt flags. Each channel supports one-shot or periodic mode. A fixed-priority encoder reports the highest-priority pending channel. It generalises the two fixed single-shot counters beside the pipeline datapath and feeds the fetch-stage interrupt vector logic. Programming comes from the execute stage: the load value is the forwarded rs operand, and channel select and mode come from decoded control.

## Interface
- `N_CH`, 4, number of timer channels (1..16)
- `CH_W`, 2, channel index width; must satisfy 2^CH_W >= N_CH
- `WIDTH`, 32, counter and reload width
- `PRESCALE`, 0, global tick every PRESCALE+1 clocks (0..255)

- `clk` in 1, single clock, rising edge
- `reset` in 1, asynchronous, active-low; low asserts
- `load_en` in 1, program channel `load_sel` this cycle
- `load_sel` in CH_W, channel to program
- `load_val` in WIDTH, start and reload value
- `load_periodic` in 1, 1 = periodic, 0 = one-shot
- `dis_en` in 1, stop channel `dis_sel` and clear its pending flag
- `dis_sel` in CH_W, channel to disable
- `ack_en` in 1, clear pending flag of channel `ack_sel`
- `ack_sel` in CH_W, channel to acknowledge
- `rd_sel` in CH_W, readback channel select
- `rd_count` out WIDTH, current count of `rd_sel` (see Configuration)
- `irq_pending` out N_CH, registered sticky flags
- `irq_any` out 1, OR of `irq_pending`
- `irq_id` out CH_W, lowest-index set bit of `irq_pending`; 0 when none is set
- `running` out N_CH, registered per-channel active flags

## Operation
- Per-channel state:
  - `count[WIDTH]`, `reload[WIDTH]`, `periodic`, `run`, `pend`
  - Reset value of all of these is 0
  - Prescaler counter resets to 0
- Prescaler:
  - Free-running counter 0..PRESCALE
  - `tick` = (prescaler == PRESCALE); the prescaler wraps to 0 on the same edge
  - Loads do not affect the prescaler
- Load, when `load_en` and `load_sel` < N_CH:
  - `count` <= `load_val`, `reload` <= `load_val`, `periodic` <= `load_periodic`, `pend` <= 0
  - `run` <= (`load_val` != 0)
  - Loading 0 leaves the channel idle and never raises `pend`
- Countdown, on `tick` with `run`=1 and no load/disable this cycle:
  - If `count` > 1: `count` <= `count` − 1
  - If `count` == 1: expiry. `pend` <= 1.
    - Periodic: `count` <= `reload`, channel stays running
    - One-shot: `count` <= 0, `run` <= 0
- Disable, when `dis_en`: `run` <= 0, `pend` <= 0; `count` and `reload` are held.
- Ack, when `ack_en`: `pend` <= 0.
- Priority among simultaneous events on the same channel:
  - Disable beats load beats expiry
  - Expiry beats ack: the pending flag stays set and the new event is not lost
- Out-of-range selects (value >= N_CH) are ignored.
- Events on different channels are fully independent in the same cycle.
- Decrement is modulo-free: `count` never underflows below 0.
- Reset asserted mid-count clears all state asynchronously. No expiry is reported after release.

## Timing
- All state updates occur on the rising `clk` edge. The effect of a load, disable or ack is visible one cycle later.
- Expiry latency with PRESCALE=0: `pend` is visible V cycles after the edge that accepted a load of V.
- Periodic mode repeats every V ticks with no dead cycle.
- With PRESCALE=P: expiry occurs on the V-th tick after the load. Latency is between (V−1)(P+1)+1 and V(P+1) cycles, depending on prescaler phase.
- `irq_any` and `irq_id` are combinational from registered `irq_pending`. There is no extra latency.
- `rd_count` is combinational from `rd_sel` and the registered count.

## Configuration
- `TIMER_BANK_READBACK_EN`
  - Defined: `rd_count` returns `count[rd_sel]`, or 0 when `rd_sel` >= N_CH.
  - Undefined: `rd_count` is tied to 0, no read mux is built, and `rd_sel` is ignored.
  - Timer behaviour is identical in both builds.

## Test plan
- **One-shot:** PRESCALE=0, load ch1 V=3 one-shot.
  - Required: `irq_pending`=4'b0010 exactly 3 cycles later, `running[1]`=0, `irq_id`=1.
  - Then ack ch1: pending clears next cycle.
- **Periodic:** load ch0 V=2 periodic, never ack.
  - Required: `pend[0]` rises at cycle 2 and stays 1. Readback (macro defined) cycles 2,1,2,1.
  - Then disable ch0: `running[0]`=0 and `pend[0]`=0 next cycle.
- **Priority:** ch2 and ch3 expire on the same cycle.
  - Required: `irq_pending`=4'b1100, `irq_id`=2.
  - Then ack ch2: `irq_id`=3.
- **Collision:** ack ch0 on the cycle ch0 re-expires (periodic V=1).
  - Required: `pend[0]` remains 1.
  - Load and disable ch1 in the same cycle: `running[1]`=0.
- **Prescaler and reset:** PRESCALE=3, load V=2.
  - Required: pend within 5..8 cycles.
  - Drive `reset` low mid-count: all outputs 0 immediately, and no pend after release.
- **Edge values:** load V=0.
  - Required: `running`=0 and no pend ever.
  - `load_sel`=5 with N_CH=4: no state change.

Source files
------------

// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
//   A bank of N_CH independent down-counting interval timers with sticky
//   interrupt flags and a fixed-priority pending-channel encoder. Each channel
//   runs one-shot or periodic. Counting advances on a shared prescaled tick.
//
// Parameters
//   N_CH     : number of channels (1..16)
//   CH_W     : channel index width, 2**CH_W >= N_CH
//   WIDTH    : counter / reload width
//   PRESCALE : a tick occurs every PRESCALE+1 clocks (0..255)
//
// Ports
//   clk           : clock, rising edge
//   reset         : asynchronous reset, active low
//   load_en/sel/val/periodic : program one channel (start value and mode)
//   dis_en/sel    : stop one channel and clear its pending flag
//   ack_en/sel    : clear one channel's pending flag
//   rd_sel        : readback channel select
//   rd_count      : count of rd_sel channel (0 when readback is not built)
//   irq_pending   : registered sticky expiry flags
//   irq_any       : OR of irq_pending
//   irq_id        : lowest-index pending channel, 0 when none
//   running       : registered per-channel active flags
//
// Build option
//   TIMER_BANK_READBACK_EN : when defined, rd_count muxes the selected count;
//                            otherwise rd_count is tied to 0.
// -----------------------------------------------------------------------------
module timer_bank #(
    parameter int N_CH     = 4,
    parameter int CH_W     = 2,
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [CH_W-1:0]  load_sel,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load_periodic,
    input  logic             dis_en,
    input  logic [CH_W-1:0]  dis_sel,
    input  logic             ack_en,
    input  logic [CH_W-1:0]  ack_sel,
    input  logic [CH_W-1:0]  rd_sel,
    output logic [WIDTH-1:0] rd_count,
    output logic [N_CH-1:0]  irq_pending,
    output logic             irq_any,
    output logic [CH_W-1:0]  irq_id,
    output logic [N_CH-1:0]  running
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
    localparam logic [7:0]       C_PRE = 8'(PRESCALE);

    logic [7:0]       r_presc;
    logic [WIDTH-1:0] r_count  [N_CH];
    logic [WIDTH-1:0] r_reload [N_CH];
    logic [N_CH-1:0]  r_periodic;
    logic [N_CH-1:0]  r_run;
    logic [N_CH-1:0]  r_pend;

    logic             w_tick;
    logic [N_CH-1:0]  w_load;
    logic [N_CH-1:0]  w_dis;
    logic [N_CH-1:0]  w_ack;
    logic [N_CH-1:0]  w_expire;
    logic [CH_W-1:0]  w_id;
    logic [WIDTH-1:0] w_rd;

    assign w_tick = (r_presc == C_PRE);

    // Free-running prescaler; loads never disturb its phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 8'd1;
        end
    end

    // Per-channel event decode. Selects outside 0..N_CH-1 match no channel.
    always_comb begin
        w_load   = '0;
        w_dis    = '0;
        w_ack    = '0;
        w_expire = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_load[i]   = load_en && (load_sel == CH_W'(i));
            w_dis[i]    = dis_en  && (dis_sel  == CH_W'(i));
            w_ack[i]    = ack_en  && (ack_sel  == CH_W'(i));
            w_expire[i] = w_tick && r_run[i] && (r_count[i] == C_ONE);
        end
    end

    // Channel state. Disable beats load beats countdown; an expiry in the
    // same cycle as an ack keeps the flag set so the event is not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_count[i]  <= '0;
                r_reload[i] <= '0;
            end
            r_periodic <= '0;
            r_run      <= '0;
            r_pend     <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_dis[i]) begin
                    r_run[i]  <= 1'b0;
                    r_pend[i] <= 1'b0;
                end else if (w_load[i]) begin
                    r_count[i]    <= load_val;
                    r_reload[i]   <= load_val;
                    r_periodic[i] <= load_periodic;
                    r_pend[i]     <= 1'b0;
                    r_run[i]      <= (load_val != '0);
                end else begin
                    if (w_expire[i]) begin
                        if (r_periodic[i]) begin
                            r_count[i] <= r_reload[i];
                        end else begin
                            r_count[i] <= '0;
                            r_run[i]   <= 1'b0;
                        end
                    end else if (w_tick && r_run[i] && (r_count[i] > C_ONE)) begin
                        r_count[i] <= r_count[i] - C_ONE;
                    end

                    if (w_expire[i]) begin
                        r_pend[i] <= 1'b1;
                    end else if (w_ack[i]) begin
                        r_pend[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Lowest index wins: scan from the top so lower channels overwrite.
    always_comb begin
        w_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_id = CH_W'(i);
            end
        end
    end

`ifdef TIMER_BANK_READBACK_EN
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_sel == CH_W'(i)) begin
                w_rd = r_count[i];
            end
        end
    end
`else
    logic w_unused_rd;
    assign w_unused_rd = ^rd_sel;
    assign w_rd        = '0;
`endif

    assign rd_count    = w_rd;
    assign irq_pending = r_pend;
    assign irq_any     = |r_pend;
    assign irq_id      = w_id;
    assign running     = r_run;

endmodule

// File: tb/tb_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_timer_bank
//   Directed bench for timer_bank. Two instances share the stimulus: dut0 with
//   PRESCALE=0 and dut3 with PRESCALE=3 (both N_CH=4, CH_W=3 so that an
//   out-of-range select such as 5 is expressible). Expected values are queued
//   with the cycle at which they must be seen and compared one time unit after
//   that clock edge.
// -----------------------------------------------------------------------------
module tb_timer_bank;

    localparam int N_CH  = 4;
    localparam int CH_W  = 3;
    localparam int WIDTH = 32;

    localparam int S_PEND  = 0;
    localparam int S_RUN   = 1;
    localparam int S_ANY   = 2;
    localparam int S_ID    = 3;
    localparam int S_RD    = 4;
    localparam int S_PEND3 = 5;
    localparam int S_RUN3  = 6;
    localparam int S_RD3   = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_en;
    logic [CH_W-1:0]  load_sel;
    logic [WIDTH-1:0] load_val;
    logic             load_periodic;
    logic             dis_en;
    logic [CH_W-1:0]  dis_sel;
    logic             ack_en;
    logic [CH_W-1:0]  ack_sel;
    logic [CH_W-1:0]  rd_sel;

    logic [WIDTH-1:0] rd0, rd3;
    logic [N_CH-1:0]  pend0, pend3, run0, run3;
    logic             any0, any3;
    logic [CH_W-1:0]  id0, id3;

    timer_bank #(.N_CH(N_CH), .CH_W(CH_W), .WIDTH(WIDTH), .PRESCALE(0)) dut0 (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_sel(load_sel), .load_val(load_val),
        .load_periodic(load_periodic),
        .dis_en(dis_en), .dis_sel(dis_sel),
        .ack_en(ack_en), .ack_sel(ack_sel),
        .rd_sel(rd_sel), .rd_count(rd0),
        .irq_pending(pend0), .irq_any(any0), .irq_id(id0), .running(run0)
    );

    timer_bank #(.N_CH(N_CH), .CH_W(CH_W), .WIDTH(WIDTH), .PRESCALE(3)) dut3 (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_sel(load_sel), .load_val(load_val),
        .load_periodic(load_periodic),
        .dis_en(dis_en), .dis_sel(dis_sel),
        .ack_en(ack_en), .ack_sel(ack_sel),
        .rd_sel(rd_sel), .rd_count(rd3),
        .irq_pending(pend3), .irq_any(any3), .irq_id(id3), .running(run3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [31:0] rdx(input logic [31:0] v);
`ifdef TIMER_BANK_READBACK_EN
        return v;
`else
        return 32'(v & 32'h0);
`endif
    endfunction

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_PEND:  return 32'(pend0);
            S_RUN:   return 32'(run0);
            S_ANY:   return 32'(any0);
            S_ID:    return 32'(id0);
            S_RD:    return rd0;
            S_PEND3: return 32'(pend3);
            S_RUN3:  return 32'(run3);
            S_RD3:   return rd3;
            default: return 32'hdeadbeef;
        endcase
    endfunction

    task automatic push(input int due, input int sel, input logic [31:0] e, input string tag);
        exp_t t;
        t.due = due; t.sel = sel; t.exp = e; t.tag = tag;
        sb.push_back(t);
    endtask

    task automatic check_due();
        int i;
        logic [31:0] o;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cyc) begin
                o = obs(sb[i].sel);
                n_chk++;
                assert (o === sb[i].exp) n_pass++;
                else $error("FAIL %s @cyc %0d: observed %0h expected %0h",
                            sb[i].tag, cyc, o, sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
            #1;
            check_due();
        end
    endtask

    task automatic idle();
        load_en = 1'b0; dis_en = 1'b0; ack_en = 1'b0;
    endtask

    task automatic load(input int ch, input logic [31:0] v, input logic per);
        load_en = 1'b1; load_sel = CH_W'(ch); load_val = v; load_periodic = per;
    endtask

    int c;

    initial begin
        reset = 1'b0; idle();
        load_sel = '0; load_val = '0; load_periodic = 1'b0;
        dis_sel = '0; ack_sel = '0; rd_sel = 3'd1;
        #2;
        // reset state
        push(cyc, S_PEND, 0, "rst_pend");
        push(cyc, S_RUN,  0, "rst_run");
        push(cyc, S_ANY,  0, "rst_any");
        push(cyc, S_ID,   0, "rst_id");
        push(cyc, S_RD,   0, "rst_rd");
        check_due();
        step(2);
        reset = 1'b1;
        step(2);

        // one-shot ch1 V=3
        c = cyc;
        push(c+1, S_RUN,  32'b0010, "os_run_on");
        push(c+1, S_RD,   rdx(3),   "os_rd3");
        push(c+2, S_RD,   rdx(2),   "os_rd2");
        push(c+3, S_PEND, 0,        "os_pend_early");
        push(c+3, S_ANY,  0,        "os_any_early");
        push(c+4, S_PEND, 32'b0010, "os_pend");
        push(c+4, S_RUN,  0,        "os_run_off");
        push(c+4, S_ID,   1,        "os_id");
        push(c+4, S_ANY,  1,        "os_any");
        push(c+4, S_RD,   rdx(0),   "os_rd0");
        load(1, 3, 1'b0);
        step(1); idle(); step(3);
        push(cyc+1, S_PEND, 0, "os_ack_pend");
        push(cyc+1, S_ANY,  0, "os_ack_any");
        push(cyc+1, S_ID,   0, "os_ack_id");
        ack_en = 1'b1; ack_sel = 3'd1;
        step(1); idle();

        // periodic ch0 V=2
        c = cyc; rd_sel = 3'd0;
        push(c+1, S_RD,   rdx(2), "per_rd_a");
        push(c+2, S_RD,   rdx(1), "per_rd_b");
        push(c+3, S_RD,   rdx(2), "per_rd_c");
        push(c+4, S_RD,   rdx(1), "per_rd_d");
        push(c+2, S_PEND, 0, "per_pend_early");
        push(c+3, S_PEND, 1, "per_pend_rise");
        push(c+4, S_PEND, 1, "per_pend_hold1");
        push(c+5, S_PEND, 1, "per_pend_hold2");
        push(c+6, S_PEND, 1, "per_pend_hold3");
        push(c+6, S_RUN,  1, "per_run");
        load(0, 2, 1'b1);
        step(1); idle(); step(5);
        push(cyc+1, S_RUN,  0,      "per_dis_run");
        push(cyc+1, S_PEND, 0,      "per_dis_pend");
        push(cyc+1, S_RD,   rdx(1), "per_dis_hold");
        dis_en = 1'b1; dis_sel = 3'd0;
        step(1); idle();

        // priority: ch2 V=4 then ch3 V=3 expire together
        c = cyc;
        push(c+4, S_PEND, 0,        "pri_early");
        push(c+5, S_PEND, 32'b1100, "pri_pend");
        push(c+5, S_ID,   2,        "pri_id2");
        push(c+5, S_ANY,  1,        "pri_any");
        load(2, 4, 1'b0);
        step(1);
        load(3, 3, 1'b0);
        step(1); idle(); step(3);
        push(cyc+1, S_PEND, 32'b1000, "pri_ack2_pend");
        push(cyc+1, S_ID,   3,        "pri_id3");
        ack_en = 1'b1; ack_sel = 3'd2;
        step(1);
        push(cyc+1, S_PEND, 0, "pri_ack3_pend");
        ack_sel = 3'd3;
        step(1); idle();

        // collision: ack while periodic V=1 re-expires
        c = cyc;
        push(c+2, S_PEND, 1, "col_pend");
        load(0, 1, 1'b1);
        step(1); idle(); step(1);
        push(cyc+1, S_PEND, 1, "col_ack_lost");
        push(cyc+1, S_RUN,  1, "col_run");
        ack_en = 1'b1; ack_sel = 3'd0;
        step(1); idle();
        push(cyc+1, S_PEND, 0, "col_dis_pend");
        push(cyc+1, S_RUN,  0, "col_dis_run");
        dis_en = 1'b1; dis_sel = 3'd0;
        step(1); idle();
        // load and disable ch1 together: disable wins, count untouched
        rd_sel = 3'd1;
        push(cyc+1, S_RUN, 0,      "ld_dis_run");
        push(cyc+1, S_RD,  rdx(0), "ld_dis_cnt");
        push(cyc+7, S_PEND, 0,     "ld_dis_nopend");
        load(1, 5, 1'b0);
        dis_en = 1'b1; dis_sel = 3'd1;
        step(1); idle(); step(6);

        // prescaler: phase known after reset release
        reset = 1'b0; #2; reset = 1'b1;
        step(2);
        c = cyc;
        push(c+1, S_RUN3,  1, "pre_run");
        push(c+5, S_PEND3, 0, "pre_early");
        push(c+6, S_PEND3, 1, "pre_pend");
        load(0, 2, 1'b0);
        step(1); idle(); step(5);

        // reset mid-count
        load(0, 3, 1'b0);
        step(1); idle(); step(1);
        reset = 1'b0;
        #1;
        push(cyc, S_PEND,  0, "ar_pend");
        push(cyc, S_RUN,   0, "ar_run");
        push(cyc, S_ANY,   0, "ar_any");
        push(cyc, S_ID,    0, "ar_id");
        push(cyc, S_RD,    0, "ar_rd");
        push(cyc, S_PEND3, 0, "ar_pend3");
        push(cyc, S_RUN3,  0, "ar_run3");
        push(cyc, S_RD3,   0, "ar_rd3");
        check_due();
        #2; reset = 1'b1;
        push(cyc+10, S_PEND,  0, "ar_nopend");
        push(cyc+10, S_PEND3, 0, "ar_nopend3");
        step(10);

        // edge values: V=0 stays idle
        c = cyc; rd_sel = 3'd0;
        push(c+1, S_RUN,  0, "v0_run");
        push(c+1, S_RD,   0, "v0_rd");
        push(c+6, S_PEND, 0, "v0_nopend");
        load(0, 0, 1'b1);
        step(1); idle(); step(5);
        // out-of-range load select
        rd_sel = 3'd5;
        push(cyc+1, S_RUN, 0, "oor_load_run");
        push(cyc+1, S_RD,  0, "oor_rd");
        load(5, 7, 1'b1);
        step(1); idle();
        // out-of-range disable/ack leave a running channel alone
        c = cyc;
        push(c+2, S_RUN,  32'b0010, "oor_dis_run");
        push(c+4, S_PEND, 32'b0010, "oor_pend");
        load(1, 3, 1'b0);
        step(1); idle();
        dis_en = 1'b1; dis_sel = 3'd5; ack_en = 1'b1; ack_sel = 3'd5;
        step(1); idle(); step(3);

        while (sb.size() > 0) begin
            n_chk++;
            $error("FAIL %s: observed none expected %0h (never compared)", sb[0].tag, sb[0].exp);
            sb.delete(0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
